// File: rtl/udp_pkg.sv
// Purpose: shared constants, FSM state type and beat-layout helper for the UDP TX framer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package udp_pkg;

    localparam int BEAT_W        = 256;
    localparam int WORD_W        = 32;
    localparam int BEATS_PER_PKT = 63;
    localparam int WORDS_PER_PKT = 489;

    localparam logic [15:0] UDP_LEN    = 16'd2016;
    localparam logic [15:0] OPCODE_SUM = 16'd1;
    localparam logic [15:0] OPCODE_MAX = 16'd2;

    localparam logic [5:0] LAST_BEAT = 6'(BEATS_PER_PKT - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        FILL,
        DRAIN
    } tx_state_t;

    // Payload words carried by a given beat: beat 1 shares space with the
    // opcode, the last beat is half full, every other payload beat is full.
    function automatic logic [3:0] words_in_beat(input logic [5:0] beat_idx);
        if (beat_idx == 6'd1)
            return 4'd5;
        else if (beat_idx == LAST_BEAT)
            return 4'd4;
        else
            return 4'd8;
    endfunction

endpackage

// File: rtl/udp_word_packer.sv
// Purpose: packs 32-bit payload words into one 256-bit beat starting at a given bit base.
// Latency: complete rises the edge after the final word of a beat is written.
// Backpressure: holds the full beat (complete=1) until take; caller must not offer words meanwhile.
//
// Ports: clk/reset (sync, active-low); take clears the buffer after the beat is consumed;
// word/valid write one word; base/words_per_beat describe the current beat's word region;
// beat_data/complete expose the assembled beat; word_done flags the final word being written.
module udp_word_packer
    import udp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              take,
    input  logic [WORD_W-1:0] word,
    input  logic              valid,
    input  logic [7:0]        base,
    input  logic [3:0]        words_per_beat,
    output logic [BEAT_W-1:0] beat_data,
    output logic              complete,
    output logic              word_done
);

    logic [3:0] cnt;
    logic [7:0] lsb;

    // k-th word of the beat lands at base + 32*k.
    assign lsb       = base + {cnt[2:0], 5'b0};
    assign word_done = valid && !complete && (cnt == words_per_beat - 4'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_data <= '0;
            cnt       <= '0;
            complete  <= 1'b0;
        end else if (take) begin
            beat_data <= '0;
            cnt       <= '0;
            complete  <= 1'b0;
        end else if (valid && !complete) begin
            beat_data[lsb +: WORD_W] <= word;
            cnt                      <= cnt + 4'd1;
            if (word_done)
                complete <= 1'b1;
        end
    end

endmodule

// File: rtl/udp_tx_framer.sv
// Purpose: frames one command + 489 payload words into a 63-beat UDP packet (header beat 0).
// Latency: beat 0 valid the cycle after command accept; payload beat valid one edge after its last word.
// Backpressure: Out_ready low holds the output beat; a full assembly buffer then drops pld_ready.
//
// Ports: clk/reset (sync, active-low); cmd_* command handshake with opcode; pld_* payload word
// handshake; Out_* 256-bit beat stream with Out_last on beat 62; seq_num = next packet's sequence.
module udp_tx_framer
    import udp_pkg::*;
#(
    parameter logic [15:0] SRC_PORT = 16'd5000,
    parameter logic [15:0] DST_PORT = 16'd5001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       cmd_opcode,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WORD_W-1:0] pld_data,
    input  logic              pld_valid,
    output logic              pld_ready,
    output logic [BEAT_W-1:0] Out_data,
    output logic              Out_valid,
    output logic              Out_last,
    input  logic              Out_ready,
    output logic [15:0]       seq_num
);

    tx_state_t         state, state_nx;
    logic [15:0]       opcode_q;
    logic [15:0]       seq_q;
    logic [5:0]        beat_idx;      // beat currently being assembled (1..62)
    logic [BEAT_W-1:0] pk_data;
    logic              pk_complete;
    logic              pk_word_done;
    logic              cmd_fire;
    logic              out_free;
    logic              take;
    logic              last_fire;

    assign seq_num   = seq_q;
    assign cmd_ready = (state == IDLE);
    assign pld_ready = (state == FILL) && !pk_complete;
    assign cmd_fire  = cmd_valid && cmd_ready;
    // Output register can accept a new beat if empty or being emptied this edge.
    assign out_free  = !Out_valid || Out_ready;
    assign take      = pk_complete && out_free;
    assign last_fire = Out_valid && Out_ready && Out_last;

    udp_word_packer u_packer (
        .clk            (clk),
        .reset          (reset),
        .take           (take),
        .word           (pld_data),
        .valid          (pld_valid && pld_ready),
        .base           ((beat_idx == LAST_BEAT) ? 8'd128 : 8'd0),
        .words_per_beat (words_in_beat(beat_idx)),
        .beat_data      (pk_data),
        .complete       (pk_complete),
        .word_done      (pk_word_done)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_valid) state_nx = HDR;
            HDR:     state_nx = FILL;
            FILL:    if (pk_word_done && beat_idx == LAST_BEAT) state_nx = DRAIN;
            DRAIN:   if (last_fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            opcode_q  <= '0;
            seq_q     <= '0;
            beat_idx  <= '0;
            Out_data  <= '0;
            Out_valid <= 1'b0;
            Out_last  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                // Output register is always empty in IDLE: DRAIN waited for the last beat.
                opcode_q  <= cmd_opcode;
                beat_idx  <= 6'd1;
                Out_data  <= {176'd0, seq_q, 16'h0000, UDP_LEN, DST_PORT, SRC_PORT};
                Out_valid <= 1'b1;
                Out_last  <= 1'b0;
            end else if (take) begin
                Out_data  <= pk_data | ((beat_idx == 6'd1) ? {80'd0, opcode_q, 160'd0} : '0);
                Out_valid <= 1'b1;
                Out_last  <= (beat_idx == LAST_BEAT);
                if (beat_idx != LAST_BEAT)
                    beat_idx <= beat_idx + 6'd1;
            end else if (Out_valid && Out_ready) begin
                Out_valid <= 1'b0;
                Out_last  <= 1'b0;
            end

            if (state == DRAIN && last_fire)
                seq_q <= seq_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Purpose: scoreboard bench for udp_tx_framer; expected beats are queued at command time.
// Latency: n/a.
// Backpressure: Out_ready driven always-on or 1-on/2-off; payload optionally gapped at random.
module tb_udp_tx_framer;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  cmd_opcode;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  pld_data;
    logic         pld_valid;
    logic         pld_ready;
    logic [255:0] Out_data;
    logic         Out_valid;
    logic         Out_last;
    logic         Out_ready;
    logic [15:0]  seq_num;

    always #5 clk = ~clk;

    udp_tx_framer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_opcode (cmd_opcode),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .pld_data   (pld_data),
        .pld_valid  (pld_valid),
        .pld_ready  (pld_ready),
        .Out_data   (Out_data),
        .Out_valid  (Out_valid),
        .Out_last   (Out_last),
        .Out_ready  (Out_ready),
        .seq_num    (seq_num)
    );

    typedef struct {
        logic [255:0] d;
        logic         last;
        int           idx;
    } exp_t;

    exp_t        expq[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_seq = 16'd0;
    int          cyc = 0;
    int          acc_count = 0;
    int          acc_cyc = -1;
    int          last_hs_cyc = -1;
    int          rdy_mode = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference beat contents built from the packet layout; payload word i carries value i+1.
    function automatic logic [255:0] exp_beat(input int b, input logic [15:0] op, input logic [15:0] sq);
        logic [255:0] d;
        d = '0;
        if (b == 0) begin
            d[15:0]  = 16'd5000;
            d[31:16] = 16'd5001;
            d[47:32] = 16'd2016;
            d[79:64] = sq;
        end else if (b == 1) begin
            for (int k = 0; k < 5; k++) d[32*k +: 32] = k + 1;
            d[175:160] = op;
        end else if (b < 62) begin
            for (int k = 0; k < 8; k++) d[32*k +: 32] = 5 + (b - 2) * 8 + k + 1;
        end else begin
            for (int k = 0; k < 4; k++) d[128 + 32*k +: 32] = 486 + k;
        end
        return d;
    endfunction

    task automatic push_pkt(input logic [15:0] op);
        exp_t e;
        for (int b = 0; b < 63; b++) begin
            e.d    = exp_beat(b, op, exp_seq);
            e.last = (b == 62);
            e.idx  = b;
            expq.push_back(e);
        end
        exp_seq = exp_seq + 16'd1;
    endtask

    task automatic monitor();
        logic         stall_pend;
        logic [255:0] hd;
        logic         hl;
        exp_t         e;
        stall_pend = 1'b0;
        hd = '0;
        hl = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_pend) begin
                checks++;
                if (!Out_valid || Out_data !== hd || Out_last !== hl) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b last=%b data=%h required held last=%b data=%h",
                             Out_valid, Out_last, Out_data, hl, hd);
                end
            end
            stall_pend = reset && Out_valid && !Out_ready;
            hd = Out_data;
            hl = Out_last;
            if (reset && Out_valid && Out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got data %h last=%b, required no beat", Out_data, Out_last);
                end else begin
                    e = expq.pop_front();
                    check($sformatf("beat%0d_data", e.idx), Out_data, e.d);
                    check($sformatf("beat%0d_last", e.idx), 256'(Out_last), 256'(e.last));
                    if (Out_last) last_hs_cyc = cyc;
                end
            end
            if (reset && cmd_valid && cmd_ready) begin
                acc_count++;
                acc_cyc = cyc;
            end
        end
    endtask

    task automatic ready_drv();
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            k++;
            Out_ready = (rdy_mode == 0) ? 1'b1 : ((k % 3) == 0);
        end
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_count < target) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 5000) begin
                checks++;
                errors++;
                $display("FAIL cmd_accept_timeout: accepted %0d required %0d", acc_count, target);
                break;
            end
        end
    endtask

    task automatic do_cmd(input logic [15:0] op);
        int target;
        @(posedge clk);
        #1;
        push_pkt(op);
        target     = acc_count + 1;
        cmd_opcode = op;
        cmd_valid  = 1'b1;
        wait_acc(target);
        cmd_valid  = 1'b0;
    endtask

    task automatic feed(input int n, input bit rnd);
        int tmo;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                while ($urandom_range(0, 1) == 0) begin
                    pld_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            pld_data  = 32'(i + 1);
            pld_valid = 1'b1;
            tmo = 0;
            forever begin
                @(negedge clk);
                if (pld_ready) break;
                tmo++;
                if (tmo > 3000) break;
            end
            if (tmo > 3000) begin
                checks++;
                errors++;
                $display("FAIL pld_timeout: word %0d not accepted, required acceptance", i);
                pld_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        pld_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (expq.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 8000) begin
                checks++;
                errors++;
                $display("FAIL beats_missing: %0d beats outstanding, required 0", expq.size());
                expq.delete();
                break;
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("seq_num_after", 256'(seq_num), 256'(exp_seq));
    endtask

    initial begin
        reset      = 1'b0;
        cmd_opcode = '0;
        cmd_valid  = 1'b0;
        pld_data   = '0;
        pld_valid  = 1'b0;
        Out_ready  = 1'b1;
        fork
            monitor();
            ready_drv();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 256'(Out_valid), 256'(0));
        check("rst_out_last", 256'(Out_last), 256'(0));
        check("rst_out_data", Out_data, '0);
        check("rst_pld_ready", 256'(pld_ready), 256'(0));
        check("rst_seq_num", 256'(seq_num), 256'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_rst", 256'(cmd_ready), 256'(1));

        // Streaming packet, sink always ready
        do_cmd(16'd1);
        feed(489, 1'b0);
        wait_done();

        // Sink stalls 2 of every 3 cycles
        rdy_mode = 1;
        do_cmd(16'd1);
        feed(489, 1'b0);
        wait_done();
        rdy_mode = 0;

        // Gapped payload
        do_cmd(16'd1);
        feed(489, 1'b1);
        wait_done();

        // Reset in the middle of a packet (around beat 31)
        do_cmd(16'd1);
        feed(245, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        expq.delete();
        exp_seq = 16'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("cmd_ready_mid_rst", 256'(cmd_ready), 256'(1));
        check("out_valid_mid_rst", 256'(Out_valid), 256'(0));
        repeat (10) @(posedge clk);
        do_cmd(16'd2);
        feed(489, 1'b0);
        wait_done();

        // Sequence number wrap
        @(posedge clk);
        #1;
        force dut.seq_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.seq_q;
        @(negedge clk);
        check("seq_preload", 256'(seq_num), 256'(16'hFFFF));
        exp_seq = 16'hFFFF;
        do_cmd(16'h0007);
        feed(489, 1'b0);
        wait_done();

        // Command held high across two packets
        @(posedge clk);
        #1;
        begin
            int base;
            base = acc_count;
            push_pkt(16'd1);
            push_pkt(16'd2);
            cmd_opcode = 16'd1;
            cmd_valid  = 1'b1;
            wait_acc(base + 1);
            cmd_opcode = 16'd2;
            feed(489, 1'b0);
            wait_acc(base + 2);
            cmd_valid = 1'b0;
            check("second_cmd_cycle", 256'(acc_cyc), 256'(last_hs_cyc + 1));
            feed(489, 1'b0);
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/udp_tx_framer.md
UDP_TX_FRAMER -- requirements
Module: udp_tx_framer

Interface
REQ-001 The block SHALL have parameter SRC_PORT, default 16'd5000, the UDP source port written into beat 0.
REQ-002 The block SHALL have parameter DST_PORT, default 16'd5001, the UDP destination port written into beat 0.
REQ-003 The block SHALL have these ports (clock and reset first):
  clk  input  1  clock; all logic on rising edge
  reset  input  1  synchronous, active-low reset
  cmd_opcode  input  16  operation code for the packet (1 = SUM, 2 = MAX; other values passed through unchanged)
  cmd_valid  input  1  command offered
  cmd_ready  output  1  command accepted when high with cmd_valid
  pld_data  input  32  payload word
  pld_valid  input  1  payload word offered
  pld_ready  output  1  payload word accepted when high with pld_valid
  Out_data  output  256  frame beat
  Out_valid  output  1  beat valid
  Out_last  output  1  high on beat 62 only
  Out_ready  input  1  downstream accepts beat
  seq_num  output  16  sequence number of the next packet
REQ-004 Reset SHALL be reset, synchronous, active-low, and the clock SHALL be clk.

Function
REQ-005 Each packet SHALL be exactly 63 beats, numbered 0..62, carrying 489 payload words.
REQ-006 Beat 0 layout SHALL be: [15:0] SRC_PORT, [31:16] DST_PORT, [47:32] 16'd2016, [63:48] 16'h0000, [79:64] seq_num, [255:80] zero.
REQ-007 Beat 1 layout SHALL be: words 0..4 at [159:0], cmd_opcode at [175:160], [255:176] zero.
REQ-008 Beats 2..61 SHALL each carry 8 words; beat 62 SHALL carry 4 words at [255:128], with [127:0] zero.
REQ-009 Within a beat, the k-th word accepted SHALL occupy bits [32k+31:32k] of that beat's word region, with word region base 0 for beats 1..61 and 128 for beat 62.
REQ-010 FSM states SHALL be IDLE, HDR, FILL and DRAIN.
REQ-011 IDLE: cmd_ready=1, pld_ready=0; a cmd_valid&&cmd_ready handshake latches the opcode and moves to HDR.
REQ-012 HDR: beat 0 SHALL be loaded into the output register and Out_valid asserted on the cycle after command acceptance; the FSM then moves to FILL.
REQ-013 FILL: pld_ready SHALL be 1 while the assembly buffer is incomplete; when the final word of a beat is accepted, the beat SHALL transfer to the output register on the next edge if the output register is empty or is handshaking that same cycle, otherwise pld_ready SHALL drop until the transfer occurs.
REQ-014 When the final word of beat 62 is accepted, the FSM SHALL enter DRAIN. DRAIN SHALL wait until beat 62 has handshaked (Out_valid&&Out_ready with Out_last=1). It SHALL then increment seq_num (16'hFFFF wraps to 16'h0000) and return to IDLE.
REQ-015 While Out_valid=1 and Out_ready=0, Out_data, Out_last and Out_valid SHALL be held stable.
REQ-016 A simultaneous output handshake and buffer-to-output transfer SHALL lose no beat and duplicate no beat.
REQ-017 Output beats SHALL be back-to-back (one per cycle) when pld_valid and Out_ready are both continuously high, apart from the beat-assembly time.
REQ-018 cmd_ready SHALL be 0 in HDR, FILL and DRAIN; a new command SHALL NOT be accepted until the previous packet's beat 62 has handshaked.

Reset
REQ-019 On reset=0 at a clock edge, state SHALL be IDLE and these signals SHALL be cleared: Out_valid=0, Out_last=0, Out_data=0, pld_ready=0, seq_num=0, and all counters and assembly buffers.
REQ-020 cmd_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-021 A reset mid-packet SHALL abandon the partial packet with no further beats emitted.

Structure
REQ-022 Package udp_pkg SHALL hold: BEAT_W=256, WORD_W=32, BEATS_PER_PKT=63, WORDS_PER_PKT=489, UDP_LEN=16'd2016, OPCODE_SUM=16'd1, OPCODE_MAX=16'd2, and the TX FSM state enum.
REQ-023 Word-to-beat assembly SHALL be one sub-module, udp_word_packer, with inputs word, valid, word-region base and words-per-beat, and outputs beat data and complete; framing, header and handshake logic SHALL stay in udp_tx_framer.

Verification
REQ-024 Opcode 1, payload words 1..489, Out_ready=1 SHALL produce 63 beats. Beat 0 [79:64]=0. Beat 1 [175:160]=1 and [159:0]={5,4,3,2,1}. Beat 62 [255:128]={489,488,487,486}, Out_last=1 on beat 62 only. seq_num SHALL be 1 afterwards.
REQ-025 Same stimulus with Out_ready toggled in a 1-on/2-off pattern SHALL produce identical beat contents, and data SHALL be held stable during every stall.
REQ-026 pld_valid randomly deasserted 50% of cycles SHALL produce identical beat contents and no extra beats.
REQ-027 Reset pulsed at beat 30 then a new opcode-2 packet SHALL emit no beats of the old packet after reset. The new packet SHALL have seq_num 0 in beat 0 and opcode 2 in beat 1.
REQ-028 Preloading seq_num to 16'hFFFF via 65535 packets, or by force, then sending one packet SHALL give beat 0 [79:64]=16'hFFFF and seq_num=0 afterwards.
REQ-029 cmd_valid held high throughout two packets SHALL result in the second command being accepted only on the cycle after beat 62 of the first packet handshakes.
